// File: rtl/tagged_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tagged_ram_ctrl
//
// Tagged main-memory controller that sits on the CPU's multiplexed external
// bus and replaces the behavioural RAM model in CPU benches. Each word holds
// 64 data bits plus an 8-bit tag. Reads are delivered through an RD_LAT-deep
// pipeline. Block-transfer mode auto-increments the word address for BLK_LEN
// accesses.
//
// Parameters
//   AW       word-address width (memory depth 2**AW)
//   RD_LAT   read latency in cycles, 1..4
//   BLK_LEN  words per block transfer, power of two, 2..16
//
// Ports
//   clk         clock, all state on posedge
//   reset       asynchronous active-high reset
//   i_ad        address (with i_astb) or write data (with i_wr)
//   i_tag       write tag
//   i_astb      address strobe (highest priority)
//   i_rd        read request (lowest priority)
//   i_wr        write request
//   o_data      read data, holds the last value between reads
//   o_tag       read tag
//   o_rvalid    one-cycle pulse when o_data/o_tag update
//   o_blk       block-transfer mode active
//
// Optional feature macro: TAGGED_RAM_PARITY_EN
//   Adds i_perr_inj (flip the stored parity bit on a write) and o_perr
//   (sticky parity-error flag, raised together with the failing o_rvalid).
// -----------------------------------------------------------------------------
module tagged_ram_ctrl #(
    parameter int AW      = 20,
    parameter int RD_LAT  = 1,
    parameter int BLK_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] i_ad,
    input  logic [7:0]  i_tag,
    input  logic        i_astb,
    input  logic        i_rd,
    input  logic        i_wr,
`ifdef TAGGED_RAM_PARITY_EN
    input  logic        i_perr_inj,
    output logic        o_perr,
`endif
    output logic [63:0] o_data,
    output logic [7:0]  o_tag,
    output logic        o_rvalid,
    output logic        o_blk
);

    localparam int CW = $clog2(BLK_LEN);

    logic [63:0]   mem    [2**AW];
    logic [7:0]    tagMem [2**AW];

    logic [AW-1:0] waddr_q, waddr_d;
    logic          blk_q, blk_d;
    logic [CW-1:0] blkCnt_q, blkCnt_d;

    logic [RD_LAT-1:0] pipeV_q;
    logic [63:0]       pipeD_q [RD_LAT];
    logic [7:0]        pipeT_q [RD_LAT];

    logic wrFire;
    logic rdFire;
    logic lastBeat;

    // Only the highest-priority strobe in a cycle takes effect.
    assign wrFire   = i_wr & ~i_astb;
    assign rdFire   = i_rd & ~i_astb & ~i_wr;
    assign lastBeat = blk_q && (blkCnt_q == CW'(BLK_LEN - 1));

    // Address latch and block-mode bookkeeping. The final access of a block
    // leaves the address where it was, so later single accesses reuse it.
    always_comb begin
        waddr_d  = waddr_q;
        blk_d    = blk_q;
        blkCnt_d = blkCnt_q;
        if (i_astb) begin
            waddr_d  = i_ad[AW-1:0];
            blk_d    = i_ad[63];
            blkCnt_d = '0;
        end else if ((wrFire || rdFire) && blk_q) begin
            if (lastBeat) begin
                blk_d = 1'b0;
            end else begin
                waddr_d  = waddr_q + AW'(1);
                blkCnt_d = blkCnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr_q  <= '0;
            blk_q    <= 1'b0;
            blkCnt_q <= '0;
        end else begin
            waddr_q  <= waddr_d;
            blk_q    <= blk_d;
            blkCnt_q <= blkCnt_d;
        end
    end

    // RAM array writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (wrFire) begin
            mem[waddr_q]    <= i_ad;
            tagMem[waddr_q] <= i_tag;
        end
    end

    // Read pipeline. Data only advances alongside a valid entry, so the last
    // stage keeps the previous read result while bubbles pass through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipeV_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipeD_q[k] <= '0;
                pipeT_q[k] <= '0;
            end
        end else begin
            pipeV_q[0] <= rdFire;
            if (rdFire) begin
                pipeD_q[0] <= mem[waddr_q];
                pipeT_q[0] <= tagMem[waddr_q];
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipeV_q[k] <= pipeV_q[k-1];
                if (pipeV_q[k-1]) begin
                    pipeD_q[k] <= pipeD_q[k-1];
                    pipeT_q[k] <= pipeT_q[k-1];
                end
            end
        end
    end

    assign o_rvalid = pipeV_q[RD_LAT-1];
    assign o_data   = pipeD_q[RD_LAT-1];
    assign o_tag    = pipeT_q[RD_LAT-1];
    assign o_blk    = blk_q;

`ifdef TAGGED_RAM_PARITY_EN
    logic              parMem [2**AW];
    logic [RD_LAT-1:0] pipeE_q;
    logic              perrSticky_q;

    // Stored parity covers data and tag; i_perr_inj deliberately corrupts it.
    always_ff @(posedge clk) begin
        if (wrFire) begin
            parMem[waddr_q] <= (^{i_ad, i_tag}) ^ i_perr_inj;
        end
    end

    // The mismatch flag travels with its read so it surfaces with o_rvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipeE_q      <= '0;
            perrSticky_q <= 1'b0;
        end else begin
            pipeE_q[0] <= rdFire &&
                          ((^{mem[waddr_q], tagMem[waddr_q]}) != parMem[waddr_q]);
            for (int k = 1; k < RD_LAT; k++) begin
                pipeE_q[k] <= pipeE_q[k-1];
            end
            perrSticky_q <= perrSticky_q | (pipeV_q[RD_LAT-1] & pipeE_q[RD_LAT-1]);
        end
    end

    assign o_perr = perrSticky_q | (pipeV_q[RD_LAT-1] & pipeE_q[RD_LAT-1]);
`endif

endmodule

// File: tb/tb_tagged_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tagged_ram_ctrl
//
// Directed bench for tagged_ram_ctrl. Two instances share the stimulus bus:
// dut0 uses the default parameters (AW=20, RD_LAT=1) for the address-wrap,
// block and priority cases; dut1 uses RD_LAT=3 for latency and mid-read
// reset cases.
// -----------------------------------------------------------------------------
module tb_tagged_ram_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] ad;
    logic [7:0]  tag;
    logic        astb;
    logic        rd;
    logic        wr;
    logic        perrInj;

    logic [63:0] data0, data1;
    logic [7:0]  tag0, tag1;
    logic        rvalid0, rvalid1;
    logic        blk0, blk1;
    logic        perr0, perr1;

    int compareCount;
    int errorCount;

    tagged_ram_ctrl dut0 (
        .clk        (clk),
        .reset      (reset),
        .i_ad       (ad),
        .i_tag      (tag),
        .i_astb     (astb),
        .i_rd       (rd),
        .i_wr       (wr),
`ifdef TAGGED_RAM_PARITY_EN
        .i_perr_inj (perrInj),
        .o_perr     (perr0),
`endif
        .o_data     (data0),
        .o_tag      (tag0),
        .o_rvalid   (rvalid0),
        .o_blk      (blk0)
    );

    tagged_ram_ctrl #(.AW(8), .RD_LAT(3), .BLK_LEN(4)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .i_ad       (ad),
        .i_tag      (tag),
        .i_astb     (astb),
        .i_rd       (rd),
        .i_wr       (wr),
`ifdef TAGGED_RAM_PARITY_EN
        .i_perr_inj (perrInj),
        .o_perr     (perr1),
`endif
        .o_data     (data1),
        .o_tag      (tag1),
        .o_rvalid   (rvalid1),
        .o_blk      (blk1)
    );

`ifndef TAGGED_RAM_PARITY_EN
    assign perr0 = 1'b0;
    assign perr1 = 1'b0;
`endif

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, observed, expected);
        end
    endtask

    // Drives one cycle of strobes, then drops them; returns 1 ns after the edge.
    task automatic applyStimulus(input logic s_astb, input logic s_wr, input logic s_rd,
                                 input logic [63:0] s_ad, input logic [7:0] s_tag);
        astb = s_astb;
        wr   = s_wr;
        rd   = s_rd;
        ad   = s_ad;
        tag  = s_tag;
        @(posedge clk);
        #1;
        astb = 1'b0;
        wr   = 1'b0;
        rd   = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        logic [63:0] v;
        compareCount = 0;
        errorCount   = 0;
        reset   = 1'b1;
        astb    = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        ad      = '0;
        tag     = '0;
        perrInj = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_data0",   data0,   64'h0);
        checkOutput("rst_tag0",    {56'h0, tag0}, 64'h0);
        checkOutput("rst_rvalid0", {63'h0, rvalid0}, 64'h0);
        checkOutput("rst_blk0",    {63'h0, blk0}, 64'h0);
        checkOutput("rst_rvalid1", {63'h0, rvalid1}, 64'h0);
        reset = 1'b0;
        idleCycle();
        idleCycle();
        checkOutput("idle_rvalid0", {63'h0, rvalid0}, 64'h0);
        checkOutput("idle_perr0",   {63'h0, perr0}, 64'h0);

        // RD_LAT=3: fill three words, then block-read them back to back.
        applyStimulus(1, 0, 0, 64'h10, 8'h00);
        applyStimulus(0, 1, 0, 64'hAAAA_0000_0000_0001, 8'hA1);
        applyStimulus(1, 0, 0, 64'h11, 8'h00);
        applyStimulus(0, 1, 0, 64'hBBBB_0000_0000_0002, 8'hB2);
        applyStimulus(1, 0, 0, 64'h12, 8'h00);
        applyStimulus(0, 1, 0, 64'hCCCC_0000_0000_0003, 8'hC3);
        applyStimulus(1, 0, 0, 64'h8000_0000_0000_0010, 8'h00);
        checkOutput("lat3_blk_on", {63'h0, blk1}, 64'h1);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("lat3_rv_e0", {63'h0, rvalid1}, 64'h0);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("lat3_rv_e1", {63'h0, rvalid1}, 64'h0);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("lat3_rv_e2",   {63'h0, rvalid1}, 64'h1);
        checkOutput("lat3_data_e2", data1, 64'hAAAA_0000_0000_0001);
        idleCycle();
        checkOutput("lat3_rv_e3",   {63'h0, rvalid1}, 64'h1);
        checkOutput("lat3_data_e3", data1, 64'hBBBB_0000_0000_0002);
        idleCycle();
        checkOutput("lat3_rv_e4",   {63'h0, rvalid1}, 64'h1);
        checkOutput("lat3_data_e4", data1, 64'hCCCC_0000_0000_0003);
        checkOutput("lat3_tag_e4",  {56'h0, tag1}, 64'hC3);
        idleCycle();
        checkOutput("lat3_rv_e5",   {63'h0, rvalid1}, 64'h0);
        checkOutput("lat3_hold",    data1, 64'hCCCC_0000_0000_0003);
        checkOutput("lat3_blk_cnt3", {63'h0, blk1}, 64'h1);

        // Reset while a read is in flight on dut1.
        applyStimulus(1, 0, 0, 64'h10, 8'h00);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_data1", data1, 64'h0);
        checkOutput("midrst_blk1",  {63'h0, blk1}, 64'h0);
        checkOutput("midrst_data0", data0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idleCycle();
            checkOutput($sformatf("midrst_norv_%0d", i), {63'h0, rvalid1}, 64'h0);
        end

        // Write, read-after-write, and re-addressed read.
        applyStimulus(1, 0, 0, 64'h12, 8'h00);
        applyStimulus(0, 1, 0, 64'hDEADBEEF_01234567, 8'h3C);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("raw_rvalid", {63'h0, rvalid0}, 64'h1);
        checkOutput("raw_data",   data0, 64'hDEADBEEF_01234567);
        checkOutput("raw_tag",    {56'h0, tag0}, 64'h3C);
        idleCycle();
        checkOutput("raw_rv_pulse", {63'h0, rvalid0}, 64'h0);
        checkOutput("raw_hold",     data0, 64'hDEADBEEF_01234567);
        applyStimulus(1, 0, 0, 64'h12, 8'h00);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("rd2_data", data0, 64'hDEADBEEF_01234567);
        checkOutput("rd2_tag",  {56'h0, tag0}, 64'h3C);

        // Block write across the top of the 20-bit address space.
        applyStimulus(1, 0, 0, 64'h8000_0000_000F_FFFE, 8'h00);
        checkOutput("blkw_on", {63'h0, blk0}, 64'h1);
        for (int i = 1; i <= 4; i++) begin
            v = 64'(i);
            applyStimulus(0, 1, 0, v, 8'(i));
            checkOutput($sformatf("blkw_blk_%0d", i), {63'h0, blk0},
                        (i < 4) ? 64'h1 : 64'h0);
        end

        // Block read of the same range.
        applyStimulus(1, 0, 0, 64'h8000_0000_000F_FFFE, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 1, 64'h0, 8'h00);
            checkOutput($sformatf("blkr_rv_%0d", i),   {63'h0, rvalid0}, 64'h1);
            checkOutput($sformatf("blkr_data_%0d", i), data0, 64'(i));
            checkOutput($sformatf("blkr_tag_%0d", i),  {56'h0, tag0}, 64'(i));
        end
        checkOutput("blkr_off", {63'h0, blk0}, 64'h0);

        // Single reads confirm the wrap placed words 3 and 4 at 0 and 1.
        applyStimulus(1, 0, 0, 64'h0, 8'h00);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("wrap_addr0", data0, 64'h3);
        applyStimulus(1, 0, 0, 64'h1, 8'h00);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("wrap_addr1", data0, 64'h4);

        // A new astb aborts a block in progress.
        applyStimulus(1, 0, 0, 64'h8000_0000_0000_0200, 8'h00);
        applyStimulus(0, 1, 0, 64'h77, 8'h07);
        applyStimulus(1, 0, 0, 64'h300, 8'h00);
        checkOutput("abort_blk", {63'h0, blk0}, 64'h0);

        // astb + wr + rd together: only the address latches.
        applyStimulus(1, 0, 0, 64'h0, 8'h00);
        applyStimulus(1, 1, 1, 64'h12, 8'hEE);
        checkOutput("prio_all_rv", {63'h0, rvalid0}, 64'h0);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("prio_all_addr", data0, 64'hDEADBEEF_01234567);
        applyStimulus(1, 0, 0, 64'h0, 8'h00);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("prio_all_mem", data0, 64'h3);

        // wr + rd together: the write wins, no read result.
        applyStimulus(1, 0, 0, 64'h30, 8'h00);
        applyStimulus(0, 1, 1, 64'h55, 8'h11);
        checkOutput("prio_wr_rv", {63'h0, rvalid0}, 64'h0);
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("prio_wr_data", data0, 64'h55);
        checkOutput("prio_wr_tag",  {56'h0, tag0}, 64'h11);

`ifdef TAGGED_RAM_PARITY_EN
        checkOutput("par_clean", {63'h0, perr0}, 64'h0);
        applyStimulus(1, 0, 0, 64'h40, 8'h00);
        perrInj = 1'b1;
        applyStimulus(0, 1, 0, 64'h1234, 8'h00);
        perrInj = 1'b0;
        applyStimulus(0, 0, 1, 64'h0, 8'h00);
        checkOutput("par_rv",   {63'h0, rvalid0}, 64'h1);
        checkOutput("par_err",  {63'h0, perr0}, 64'h1);
        idleCycle();
        checkOutput("par_sticky", {63'h0, perr0}, 64'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
